hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core. Detects load-use and control hazards and generates the per-stage stall/flush strobes. FlushE drives the select of the control-bubble mux in front of the ID/EX register. Also generates EX operand forwarding selects, freezes the pipe during multi-cycle data-memory accesses with a timeout watchdog, and keeps saturating stall/flush event counters for performance debug.

---
 rtl/hazard_pkg.sv | 35 +++
 rtl/sat_counter.sv | 25 ++
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: FSM states and EX forwarding selects.
// No logic of its own; fwdSel is a pure combinational helper.
// Imported by hazard_ctrl.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hazState_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // MEM is the younger producer, so it wins over WB. x0 always reads the register file.
    function automatic logic [1:0] fwdSel(
        input logic [4:0] rs,
        input logic [4:0] rdM,
        input logic       regWriteM,
        input logic [4:0] rdW,
        input logic       regWriteW
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rs != 5'd0) begin
            if (regWriteM && (rdM == rs)) begin
                sel = FWD_MEM;
            end else if (regWriteW && (rdW == rs)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Purpose: event counter that sticks at all-ones; clr has priority over inc.
// Latency: count reflects inc/clr one clk edge later.
// Backpressure: none; counts every cycle inc is high.
// Ports: clk, rst (async active-low), inc, clr, count[W-1:0].
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: RV32 5-stage hazard unit - stall/flush strobes, EX forwarding, mem-wait watchdog, perf counters.
// Latency: strobes and forward selects are combinational; counters/timer/MemTimeout update on clk.
// Backpressure: a data-memory wait freezes F..M and bubbles WB until MemReadyM returns.
// Ports: ID/EX/MEM/WB register ids and write enables in; Stall*/Flush*/Forward* strobes,
//        StallCount/FlushCount and the sticky MemTimeout flag out.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             MemReadE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic             CountClear,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             MemTimeout
);

    localparam int             TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT);

    logic memWait;
    logic loadUse;

    assign memWait = MemReqM & ~MemReadyM;
    assign loadUse = MemReadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

    // Memory wait outranks everything: the whole pipe is frozen, so a branch or
    // load-use seen in EX this cycle is simply re-evaluated once the pipe moves.
    // A taken branch squashes the ID instruction, making any load-use moot.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!rst) begin
            // Hold bubbles in every flushable register while reset is asserted.
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            if (memWait) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (loadUse) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
            ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
        end
    end

    hazState_t     state;
    logic [TW-1:0] waitTimer;
    logic [TW-1:0] timerNext;

    assign timerNext = (waitTimer == TMAX) ? TMAX : waitTimer + 1'b1;

    // The timer counts cycles spent in WAIT; the first stalled cycle is spent in
    // RUN, so the flag rises after TIMEOUT WAIT cycles with the request still open.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            waitTimer  <= '0;
            MemTimeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (memWait) begin
                        state     <= WAIT;
                        waitTimer <= '0;
                    end
                end
                WAIT: begin
                    if (memWait) begin
                        waitTimer <= timerNext;
                        if (timerNext == TMAX) begin
                            MemTimeout <= 1'b1;
                        end
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) uStallCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (StallF),
        .clr   (CountClear),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (FlushE),
        .clr   (CountClear),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: self-checking bench for hazard_ctrl against a behavioural reference model.
// Latency: strobes checked on the falling edge against same-cycle inputs.
// Backpressure: memory-wait, timeout and async-reset sequences plus randomized traffic.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic MemReadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM, CountClear;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCount, FlushCount;
    logic MemTimeout;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   mStall;
    int   mFlush;
    int   mRun;       // consecutive cycles with an outstanding, not-ready memory request
    logic mTimeout;

    typedef struct packed {
        logic       sF, sD, sE, sM, fD, fE, fW;
        logic [1:0] fa, fb;
    } strobes_t;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .MemReadE(MemReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .CountClear(CountClear),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCount(StallCount), .FlushCount(FlushCount), .MemTimeout(MemTimeout)
    );

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] refFwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (RegWriteM && RdM == rs) return 2'b10;
        if (RegWriteW && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic strobes_t refStrobes();
        strobes_t s;
        bit mw, lu;
        s = '0;
        if (!rst) begin
            s.fD = 1'b1; s.fE = 1'b1; s.fW = 1'b1;
            return s;
        end
        mw = MemReqM && !MemReadyM;
        lu = MemReadE && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
        if (mw) begin
            s.sF = 1'b1; s.sD = 1'b1; s.sE = 1'b1; s.sM = 1'b1; s.fW = 1'b1;
        end else if (PCSrcE) begin
            s.fD = 1'b1; s.fE = 1'b1;
        end else if (lu) begin
            s.sF = 1'b1; s.sD = 1'b1; s.fE = 1'b1;
        end
        s.fa = refFwd(Rs1E);
        s.fb = refFwd(Rs2E);
        return s;
    endfunction

    task automatic resetModel();
        mStall = 0; mFlush = 0; mRun = 0; mTimeout = 1'b0;
    endtask

    task automatic modelEdge();
        strobes_t e;
        if (!rst) begin
            resetModel();
            return;
        end
        e = refStrobes();
        if (CountClear) begin
            mStall = 0; mFlush = 0;
        end else begin
            if (e.sF && mStall < CNT_MAX) mStall++;
            if (e.fE && mFlush < CNT_MAX) mFlush++;
        end
        if (MemReqM && !MemReadyM) begin
            mRun++;
            // first stalled cycle plus TIMEOUT further cycles of waiting
            if (mRun > TIMEOUT) mTimeout = 1'b1;
        end else begin
            mRun = 0;
        end
    endtask

    task automatic checkAll();
        strobes_t e;
        e = refStrobes();
        checkEq("StallF", StallF, e.sF);
        checkEq("StallD", StallD, e.sD);
        checkEq("StallE", StallE, e.sE);
        checkEq("StallM", StallM, e.sM);
        checkEq("FlushD", FlushD, e.fD);
        checkEq("FlushE", FlushE, e.fE);
        checkEq("FlushW", FlushW, e.fW);
        checkEq("ForwardAE", ForwardAE, e.fa);
        checkEq("ForwardBE", ForwardBE, e.fb);
        checkEq("StallCount", StallCount, mStall);
        checkEq("FlushCount", FlushCount, mFlush);
        checkEq("MemTimeout", MemTimeout, mTimeout);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic stepChk();
        @(negedge clk);
        checkAll();
        tick();
    endtask

    task automatic clearIns();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        MemReadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0; CountClear = 0;
    endtask

    // Small register pool so that matches happen often.
    function automatic logic [4:0] randReg();
        logic [4:0] r;
        case ($urandom_range(0, 4))
            0: r = 5'd0;
            1: r = 5'd1;
            2: r = 5'd5;
            3: r = 5'd7;
            default: r = 5'($urandom_range(0, 31));
        endcase
        return r;
    endfunction

    initial begin
        clearIns();
        rst = 1'b0;
        resetModel();

        // Reset: busy inputs must not leak through.
        PCSrcE = 1; MemReqM = 1; MemReadE = 1; RdE = 3; Rs1D = 3;
        RegWriteM = 1; RdM = 3; Rs1E = 3;
        @(negedge clk);
        checkAll();
        checkEq("rstFlushD", FlushD, 1);
        checkEq("rstStallF", StallF, 0);
        checkEq("rstFwdA", ForwardAE, 2'b00);
        checkEq("rstCount", StallCount, 0);
        tick();
        tick();
        rst = 1'b1;
        clearIns();

        // Load-use: one bubble, then forward from WB.
        CountClear = 1;
        stepChk();
        CountClear = 0;
        MemReadE = 1; RdE = 5; Rs1D = 5; Rs2D = 9;
        @(negedge clk);
        checkAll();
        checkEq("luStallF", StallF, 1);
        checkEq("luStallD", StallD, 1);
        checkEq("luFlushE", FlushE, 1);
        tick();
        MemReadE = 0; RdE = 0; RdM = 5; RegWriteM = 1;
        @(negedge clk);
        checkAll();
        checkEq("luOnce", StallF, 0);
        tick();
        RegWriteM = 0; RdM = 0; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs1D = 0;
        @(negedge clk);
        checkAll();
        checkEq("luFwdWB", ForwardAE, 2'b01);
        checkEq("luStallCnt", StallCount, 1);
        checkEq("luFlushCnt", FlushCount, 1);
        tick();

        // Load to x0 never stalls.
        clearIns();
        MemReadE = 1; RdE = 0; Rs1D = 0;
        @(negedge clk);
        checkAll();
        checkEq("x0Stall", StallF, 0);
        checkEq("x0Flush", FlushE, 0);
        tick();

        // Double forward: MEM beats WB, then WB alone.
        clearIns();
        RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs1E = 7; Rs2E = 7;
        @(negedge clk);
        checkAll();
        checkEq("dfA", ForwardAE, 2'b10);
        checkEq("dfB", ForwardBE, 2'b10);
        tick();
        RegWriteM = 0;
        @(negedge clk);
        checkAll();
        checkEq("dfAwb", ForwardAE, 2'b01);
        checkEq("dfBwb", ForwardBE, 2'b01);
        tick();

        // Branch together with load-use: branch wins.
        clearIns();
        PCSrcE = 1; MemReadE = 1; RdE = 4; Rs2D = 4;
        @(negedge clk);
        checkAll();
        checkEq("brFlushD", FlushD, 1);
        checkEq("brFlushE", FlushE, 1);
        checkEq("brStallF", StallF, 0);
        tick();

        // Memory wait of 3 cycles with a branch pending.
        clearIns();
        CountClear = 1;
        stepChk();
        CountClear = 0;
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkAll();
            checkEq("mwStallM", StallM, 1);
            checkEq("mwFlushW", FlushW, 1);
            checkEq("mwFlushD", FlushD, 0);
            tick();
        end
        MemReadyM = 1; PCSrcE = 0;
        @(negedge clk);
        checkAll();
        checkEq("mwDone", StallF, 0);
        checkEq("mwCount", StallCount, 3);
        tick();
        clearIns();
        stepChk();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            Rs1D = randReg(); Rs2D = randReg(); Rs1E = randReg(); Rs2E = randReg();
            RdE = randReg(); RdM = randReg(); RdW = randReg();
            MemReadE   = ($urandom_range(0, 2) == 0);
            RegWriteM  = $urandom_range(0, 1) == 1;
            RegWriteW  = $urandom_range(0, 1) == 1;
            PCSrcE     = ($urandom_range(0, 4) == 0);
            MemReqM    = ($urandom_range(0, 2) == 0);
            MemReadyM  = ($urandom_range(0, 2) == 0);
            CountClear = ($urandom_range(0, 24) == 0);
            stepChk();
        end

        // Timeout: fresh reset, then ready held low for 6 cycles.
        clearIns();
        rst = 1'b0;
        resetModel();
        stepChk();
        rst = 1'b1;
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkAll();
            if (i == 4) checkEq("toBefore", MemTimeout, 0);
            if (i == 5) checkEq("toSet", MemTimeout, 1);
            tick();
        end
        MemReadyM = 1;
        stepChk();
        MemReqM = 0; MemReadyM = 0;
        @(negedge clk);
        checkAll();
        checkEq("toHeld", MemTimeout, 1);
        tick();

        // Counter saturation, then clear beats increment.
        CountClear = 1;
        stepChk();
        CountClear = 0;
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 20; i++) stepChk();
        @(negedge clk);
        checkEq("satStall", StallCount, CNT_MAX);
        CountClear = 1;
        tick();
        CountClear = 0;
        @(negedge clk);
        checkAll();
        checkEq("clrWins", StallCount, 0);
        tick();

        // Async reset mid-wait.
        #2;
        rst = 1'b0;
        resetModel();
        #1;
        checkAll();
        checkEq("arStallF", StallF, 0);
        checkEq("arFlushW", FlushW, 1);
        checkEq("arFlushD", FlushD, 1);
        checkEq("arCount", StallCount, 0);
        checkEq("arTimeout", MemTimeout, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) stepChk();
        clearIns();
        for (int i = 0; i < 3; i++) stepChk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
